alu_stage: RTL
==============

ALU_STAGE -- requirements
Module: alu_stage

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; equals register-file data width.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clock  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 start  in  1  request; a, b, fun_sel sampled on the clock edge where start=1 and busy=0.
REQ-006 a  in  WIDTH  operand A, driven from register-file O1.
REQ-007 b  in  WIDTH  operand B, driven from register-file O2.
REQ-008 fun_sel  in  4  operation code.
REQ-009 out  out  WIDTH  registered result (low byte for MUL).
REQ-010 out_hi  out  WIDTH  registered high byte of MUL product; 0 for other ops.
REQ-011 flags  out  4  registered {Z,C,N,O}, bit3=Z, bit2=C, bit1=N, bit0=O.
REQ-012 busy  out  1  high while a multi-cycle op is in progress.
REQ-013 done  out  1  one-cycle pulse; out/out_hi/flags valid and stable from this cycle.

Function
REQ-014 Codes: 0 A; 1 B; 2 ~A; 3 ~B; 4 A+B; 5 A+B+C; 6 A-B; 7 A&B; 8 A|B; 9 A^B; A LSL A; B LSR A; C ASR A; D rotate-left A through C; E rotate-right A through C; F MUL.
REQ-015 FSM states IDLE, MUL, DONE; IDLE->DONE on single-cycle op, IDLE->MUL on code F, MUL->DONE after 8th iteration, DONE->IDLE unconditionally.
REQ-016 Single-cycle ops: result and flags registered on the sampling edge; done high the following cycle (latency 1); back-to-back start in the done cycle is accepted.
REQ-017 MUL: unsigned shift-add, one multiplier bit per cycle, busy=1 for 8 cycles, done 9 cycles after sampling edge, busy=0 in done cycle.
REQ-018 start while busy=1 SHALL be ignored with no effect on state or outputs.
REQ-019 Z,N updated by every op (N = result MSB); C updated by codes 4-6 and A-E only; O updated by codes 4-6 only; others hold.
REQ-020 C on add = carry-out; C on subtract = borrow (1 when A<B unsigned); O = signed two's-complement overflow.
REQ-021 Shifts: C = bit shifted out; ASR replicates MSB; rotates insert old C.
REQ-022 MUL flags: Z = 16-bit product zero, N = product bit15, C = (out_hi != 0), O held.
REQ-023 out_hi SHALL be cleared by every non-MUL op.

Reset
REQ-024 reset SHALL force out=0, out_hi=0, flags=0, busy=0, done=0, state IDLE, on the next edge, including mid-MUL (partial product discarded, no done).
REQ-025 reset SHALL take priority over start on the same edge.

Configuration
REQ-026 Macro ALU_STAGE_MUL_EN: defined -> code F is MUL per REQ-017/022.
REQ-027 Without ALU_STAGE_MUL_EN: no multiplier logic or MUL state; code F is a NOP: out, out_hi, flags hold, done pulses at latency 1, busy never asserts.

Structure
REQ-028 Package alu_pkg SHALL hold fun_sel code constants, flag bit indices, FSM state typedef.
REQ-029 Sub-module alu_mul_seq (iterative shift-add multiplier, start/done) SHALL be instantiated only under ALU_STAGE_MUL_EN.

Verification
REQ-030 a=0x7F, b=0x01, code 4 -> next-cycle done, out=0x80, flags Z0 C0 N1 O1.
REQ-031 a=0x05, b=0x05, code 6 -> out=0x00, flags Z1 C0 N0 O0; then a=0x03, b=0x05, code 6 -> out=0xFE, C1 N1.
REQ-032 MUL enabled, a=0x10, b=0x10, code F -> busy 8 cycles, done at cycle 9, out=0x00, out_hi=0x01, Z0 C1 N0.
REQ-033 MUL in progress, start with code 0 at cycle 3 -> ignored; product unchanged; reset at cycle 5 -> all outputs 0, no done.
REQ-034 C=1, a=0x81, code D -> out=0x03, C1; then code E with a=0x01 -> out=0x80, C1.
REQ-035 MUL disabled, flags=0b0100, code F -> done after 1 cycle, out/flags unchanged, busy never high.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU stage: operation codes, flag bit positions and FSM states.
// The MUL state exists only when ALU_STAGE_MUL_EN is defined.
package alu_pkg;

    localparam logic [3:0] OP_PASS_A = 4'h0;
    localparam logic [3:0] OP_PASS_B = 4'h1;
    localparam logic [3:0] OP_NOT_A  = 4'h2;
    localparam logic [3:0] OP_NOT_B  = 4'h3;
    localparam logic [3:0] OP_ADD    = 4'h4;
    localparam logic [3:0] OP_ADC    = 4'h5;
    localparam logic [3:0] OP_SUB    = 4'h6;
    localparam logic [3:0] OP_AND    = 4'h7;
    localparam logic [3:0] OP_OR     = 4'h8;
    localparam logic [3:0] OP_XOR    = 4'h9;
    localparam logic [3:0] OP_LSL    = 4'hA;
    localparam logic [3:0] OP_LSR    = 4'hB;
    localparam logic [3:0] OP_ASR    = 4'hC;
    localparam logic [3:0] OP_ROL    = 4'hD;
    localparam logic [3:0] OP_ROR    = 4'hE;
    localparam logic [3:0] OP_MUL    = 4'hF;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef ALU_STAGE_MUL_EN
        ST_MUL  = 2'd1,
`endif
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_stage_if.sv
// Request/response bundle between the register-file side and the ALU stage.
interface alu_stage_if #(parameter int WIDTH = 8);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       fun_sel;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_hi;
    logic [3:0]       flags;
    logic             busy;
    logic             done;

    modport master (output start, a, b, fun_sel,
                    input  out, out_hi, flags, busy, done);

    modport slave  (input  start, a, b, fun_sel,
                    output out, out_hi, flags, busy, done);

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per clock.
// done and product are combinational: they flag the cycle whose closing edge completes the product.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic               active_q, active_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH:0]     acc_sum;
    logic [2*WIDTH-1:0] prod_step;

    // Upper half accumulates the multiplicand, lower half holds the remaining multiplier bits.
    always_comb begin
        acc_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_step = {acc_sum, prod_q[WIDTH-1:1]};
        done      = active_q && (cnt_q == CNT_W'(WIDTH - 1));
        product   = prod_step;
    end

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
            mcand_d  = a;
            prod_d   = {{WIDTH{1'b0}}, b};
        end else if (active_q) begin
            prod_d = prod_step;
            cnt_d  = cnt_q + 1'b1;
            if (done) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
        end
    end

endmodule

// File: rtl/alu_stage.sv
// ALU execute stage: single-cycle logic/arith/shift ops with registered result and {Z,C,N,O} flags.
// Define ALU_STAGE_MUL_EN to make code F a multi-cycle multiply; otherwise code F is a NOP.
module alu_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic      clock,
    input  logic      reset,
    alu_stage_if.slave bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] out_hi_q, out_hi_d;
    logic [3:0]       flags_q, flags_d;
    logic [WIDTH-1:0] alu_res;
    logic [3:0]       alu_flags;
    logic [WIDTH:0]   alu_sum;
    logic             c_new, o_new;
    logic             busy;
    logic             accept;

`ifdef ALU_STAGE_MUL_EN
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .done    (mul_done),
        .product (mul_product)
    );

    assign busy = (state_q == ST_MUL);
`else
    assign busy = 1'b0;
`endif

    assign accept     = bus.start && !busy;
    assign bus.out    = out_q;
    assign bus.out_hi = out_hi_q;
    assign bus.flags  = flags_q;
    assign bus.busy   = busy;
    assign bus.done   = (state_q == ST_DONE);

    // Flags not touched by an op keep their previous value; subtract reports borrow in C.
    always_comb begin
        alu_res = bus.a;
        alu_sum = '0;
        c_new   = flags_q[FLAG_C];
        o_new   = flags_q[FLAG_O];
        case (bus.fun_sel)
            OP_PASS_A: alu_res = bus.a;
            OP_PASS_B: alu_res = bus.b;
            OP_NOT_A:  alu_res = ~bus.a;
            OP_NOT_B:  alu_res = ~bus.b;
            OP_ADD, OP_ADC: begin
                alu_sum = {1'b0, bus.a} + {1'b0, bus.b}
                        + {{WIDTH{1'b0}}, (bus.fun_sel == OP_ADC) && flags_q[FLAG_C]};
                alu_res = alu_sum[WIDTH-1:0];
                c_new   = alu_sum[WIDTH];
                o_new   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_sum = {1'b0, bus.a} - {1'b0, bus.b};
                alu_res = alu_sum[WIDTH-1:0];
                c_new   = alu_sum[WIDTH];
                o_new   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND: alu_res = bus.a & bus.b;
            OP_OR:  alu_res = bus.a | bus.b;
            OP_XOR: alu_res = bus.a ^ bus.b;
            OP_LSL: begin
                alu_res = {bus.a[WIDTH-2:0], 1'b0};
                c_new   = bus.a[WIDTH-1];
            end
            OP_LSR: begin
                alu_res = {1'b0, bus.a[WIDTH-1:1]};
                c_new   = bus.a[0];
            end
            OP_ASR: begin
                alu_res = {bus.a[WIDTH-1], bus.a[WIDTH-1:1]};
                c_new   = bus.a[0];
            end
            OP_ROL: begin
                alu_res = {bus.a[WIDTH-2:0], flags_q[FLAG_C]};
                c_new   = bus.a[WIDTH-1];
            end
            OP_ROR: begin
                alu_res = {flags_q[FLAG_C], bus.a[WIDTH-1:1]};
                c_new   = bus.a[0];
            end
            default: alu_res = bus.a;
        endcase
        alu_flags         = '0;
        alu_flags[FLAG_Z] = (alu_res == '0);
        alu_flags[FLAG_C] = c_new;
        alu_flags[FLAG_N] = alu_res[WIDTH-1];
        alu_flags[FLAG_O] = o_new;
    end

    // A new request is taken in IDLE and also in DONE, so back-to-back ops lose no cycle.
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        out_hi_d = out_hi_q;
        flags_d  = flags_q;
`ifdef ALU_STAGE_MUL_EN
        mul_start = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    state_d = ST_DONE;
                    if (bus.fun_sel == OP_MUL) begin
`ifdef ALU_STAGE_MUL_EN
                        mul_start = 1'b1;
                        state_d   = ST_MUL;
`endif
                    end else begin
                        out_d    = alu_res;
                        out_hi_d = '0;
                        flags_d  = alu_flags;
                    end
                end
            end
`ifdef ALU_STAGE_MUL_EN
            ST_MUL: begin
                if (mul_done) begin
                    out_d            = mul_product[WIDTH-1:0];
                    out_hi_d         = mul_product[2*WIDTH-1:WIDTH];
                    flags_d[FLAG_Z]  = (mul_product == '0);
                    flags_d[FLAG_C]  = (mul_product[2*WIDTH-1:WIDTH] != '0);
                    flags_d[FLAG_N]  = mul_product[2*WIDTH-1];
                    state_d          = ST_DONE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            out_q    <= '0;
            out_hi_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            out_hi_q <= out_hi_d;
            flags_q  <= flags_d;
        end
    end

endmodule
